mdio_master: RTL
================

Name: mdio_master

Overview:
MDIO (IEEE 802.3 clause 22) management controller that drives the PHY's MDC/MDIO pins, which the top level currently leaves unused. It accepts single register read/write commands over a valid/ready handshake, serialises the management frame and returns read data with a one-cycle response pulse. It lets the design configure and poll the TI PHY (reset, autoneg, link status) alongside the MII MAC datapath.

Parameters:
CLK_DIV, 20, system clocks per MDC half-period; MDC period = 2*CLK_DIV clocks; legal range >= 1 (20 at 100 MHz gives 2.5 MHz).
PREAMBLE_BITS, 32, number of preamble '1' bits sent before ST; 0 means preamble suppressed; legal range 0..32.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  controller idle, can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_phy_addr  input  5  PHY address
cmd_reg_addr  input  5  register address
cmd_wdata  input  16  write data; ignored for reads
rsp_valid  output  1  one-cycle pulse, transaction complete
rsp_rdata  output  16  read data; 0x0000 after a write
rsp_error  output  1  read turnaround bit sampled as 1 (no PHY answered)
busy  output  1  frame in progress
mdc  output  1  management clock to PHY
mdio_o  output  1  MDIO output value
mdio_t  output  1  tristate control; 1 = released/input, 0 = driven
mdio_i  input  1  MDIO pad input

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, mdc=0, mdio_o=1, mdio_t=1.
- Reset mid-frame: the next cycle is IDLE with all reset values, no rsp_valid and the frame is abandoned.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state==IDLE). All cmd_* fields are latched at acceptance.
- While busy, cmd_valid is ignored. The source holds the command until cmd_ready rises.
- Frame: N = PREAMBLE_BITS+32 bits, MSB first. Fields in order: preamble 1s; ST=01; OP (write 01, read 10); PHYAD[4:0]; REGAD[4:0]; TA; DATA[15:0].
- Write TA is driven as 1,0. Read TA and DATA bits are released (mdio_t=1).
- For reads, mdio_t=0 only for preamble through REGAD (PREAMBLE_BITS+14 bits). For writes, mdio_t=0 for all N bits. mdio_t returns to 1 when the frame ends.
- Bit timing: each bit has a low phase (mdc=0, CLK_DIV cycles) then a high phase (mdc=1, CLK_DIV cycles).
  - mdio_o/mdio_t update in the first cycle of the low phase, so they change on the MDC falling edge and are stable at the rising edge.
  - The first bit's low phase begins in the cycle after acceptance.
- Read sampling: mdio_i is sampled in the cycle mdc goes 0->1.
  - Second TA bit: a sampled 1 sets the error flag.
  - DATA bits: shifted in MSB first.
- The half-period counter counts 0..CLK_DIV-1 and wraps. The bit counter counts 0..N-1. Phase and bit changes happen only on counter wrap.
- FSM states: IDLE -> PREAMBLE (skipped when PREAMBLE_BITS=0) -> HEADER (14 bits ST/OP/PHY/REG) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
- DONE lasts 1 cycle. In DONE: mdc=0, mdio_t=1, mdio_o=1, rsp_valid=1, and rsp_rdata/rsp_error update.
- DONE is reached exactly 2*CLK_DIV*N+1 cycles after the acceptance cycle.
- In DONE, cmd_ready=0; it rises the following cycle. The earliest back-to-back acceptance is DONE+1.
- rsp_rdata/rsp_error hold until the next DONE. For writes, rsp_rdata=0 and rsp_error=0.
- busy = !cmd_ready.
- rsp_valid has no ready; the consumer must take it in the pulse cycle.

Test Plan:
- CLK_DIV=2, PREAMBLE_BITS=32, write phy=1 reg=0 data=0x3100 -> MDC period 4 clocks; serial stream 32x'1',01,01,00001,00000,10,0011000100000000; mdio_t=0 throughout; rsp_valid at acceptance+257, rsp_rdata=0.
- Read phy=1 reg=1 with a PHY model driving TA 0 then 0x7809 after falling edges -> mdio_t releases after bit 45; rsp_rdata=0x7809, rsp_error=0, rsp_valid at acceptance+257.
- Read with mdio_i tied 1 (no PHY) -> rsp_error=1, rsp_rdata=0xFFFF.
- cmd_valid held high with two queued commands -> second accepted exactly 1 cycle after the first rsp_valid; no command dropped; cmd_valid during busy produces no extra frame.
- Assert reset during bit 20 of a write -> next cycle mdc=0, mdio_t=1, cmd_ready=1, no rsp_valid; a new read afterwards completes correctly.
- PREAMBLE_BITS=0, CLK_DIV=1 read -> 32-bit frame starting with ST=01; rsp_valid at acceptance+65.

Source files
------------

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: accepts one register read/write command at a time,
// serialises the frame on MDC/MDIO and returns read data with a one-cycle response pulse.
module mdio_master #(
  parameter int unsigned CLK_DIV       = 20,
  parameter int unsigned PREAMBLE_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int unsigned N    = PREAMBLE_BITS + 32;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [6:0]      PreLast  = 7'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [6:0]      HdrLast  = 7'(PREAMBLE_BITS + 13);
  localparam logic [6:0]      TaLast   = 7'(PREAMBLE_BITS + 15);
  localparam logic [6:0]      DataLast = 7'(N - 1);

  typedef enum logic [2:0] {StIdle, StPreamble, StHeader, StTa, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              phase_q, phase_d;
  logic [6:0]        bit_q, bit_d;
  logic [31:0]       sh_q, sh_d;
  logic              wr_q, wr_d;
  logic [15:0]       rx_q, rx_d;
  logic              err_q, err_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  logic in_frame, half_end, bit_end, sample;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wr_d     = wr_q;
    rx_d     = rx_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;

    in_frame = (state_q == StPreamble) || (state_q == StHeader) ||
               (state_q == StTa) || (state_q == StData);
    half_end = in_frame && (div_q == DivLast);
    bit_end  = half_end && phase_q;
    // mdc is combinational from phase_q, so this is the cycle mdc rises
    sample   = in_frame && phase_q && (div_q == '0);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          sh_d    = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                     (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          rx_d    = '0;
          err_d   = 1'b0;
          state_d = (PREAMBLE_BITS == 0) ? StHeader : StPreamble;
        end
      end
      StPreamble, StHeader, StTa, StData: begin
        if (half_end) begin
          div_d   = '0;
          phase_d = ~phase_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        if (bit_end) begin
          bit_d = bit_q + 1'b1;
          if (state_q != StPreamble) sh_d = {sh_q[30:0], 1'b1};
          unique case (state_q)
            StPreamble: if (bit_q == PreLast)  state_d = StHeader;
            StHeader:   if (bit_q == HdrLast)  state_d = StTa;
            StTa:       if (bit_q == TaLast)   state_d = StData;
            default:    if (bit_q == DataLast) state_d = StDone;
          endcase
        end
        if (sample && !wr_q) begin
          if (state_q == StTa && bit_q == TaLast) err_d = mdio_i;
          if (state_q == StData) rx_d = {rx_q[14:0], mdio_i};
        end
      end
      StDone: begin
        rdata_d = wr_q ? 16'h0000 : rx_q;
        rerr_d  = wr_q ? 1'b0 : err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '1;
      wr_q    <= 1'b0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == StDone);
  assign rsp_rdata = rsp_valid ? rdata_d : rdata_q;
  assign rsp_error = rsp_valid ? rerr_d : rerr_q;
  assign mdc       = in_frame && phase_q;
  assign mdio_o    = (in_frame && state_q != StPreamble) ? sh_q[31] : 1'b1;
  // Reads release the line from TA onward so the PHY can answer
  assign mdio_t    = in_frame ? ((state_q == StTa || state_q == StData) ? ~wr_q : 1'b0) : 1'b1;

endmodule
